mul_add_row: RTL and testbench

Parametrised, pipelined successor to the single-word multiply-add cell used by MonPro. It computes one full multi-word row of the CIOS inner loop, (C,S[j]) = x*y[j] + z[j] + C for j = 0..NUM_WORDS-1, at one word per cycle. The carry is chained internally, and the block exposes valid/ready streaming on both sides. It sits between the MonPro operand word memories and the row-result writeback.

---
 rtl/mul_add_row_pkg.sv | 14 +
 rtl/mul_add_row_mul_pipe.sv | 49 ++++
 rtl/mul_add_row.sv | 187 ++++++++++++++++++
 tb/tb_mul_add_row.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_add_row_pkg.sv
// Shared defaults and FSM state type for the CIOS row multiply-add block.
package mul_add_row_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int NUM_WORDS_DEF  = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mul_add_row_mul_pipe.sv
// Unsigned W x W -> 2W multiplier with PIPE_STAGES enabled registers and a valid pass-through.
module mul_pipe #(
  parameter int DATA_WIDTH  = 64,
  parameter int PIPE_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      out_valid,
  output logic [2*DATA_WIDTH-1:0]   p
);

  logic [2*DATA_WIDTH-1:0] p_q [PIPE_STAGES];
  logic [2*DATA_WIDTH-1:0] p_d [PIPE_STAGES];
  logic [PIPE_STAGES-1:0]  v_q;
  logic [PIPE_STAGES-1:0]  v_d;

  always_comb begin
    p_d = p_q;
    v_d = v_q;
    if (en) begin
      p_d[0] = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
      v_d[0] = in_valid;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        p_d[i] = p_q[i-1];
        v_d[i] = v_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
        p_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      p_q <= p_d;
    end
  end

  assign out_valid = v_q[PIPE_STAGES-1];
  assign p         = p_q[PIPE_STAGES-1];

endmodule

// File: rtl/mul_add_row.sv
// One CIOS row (C,S[j]) = x*y[j] + z[j] + C, streamed one word per cycle with a chained carry.
module mul_add_row
  import mul_add_row_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int NUM_WORDS   = NUM_WORDS_DEF,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = $clog2(NUM_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] carry_in,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic [DATA_WIDTH-1:0] z_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] s_out,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] c_final,
  output logic                  done
);

  localparam logic [CNT_W-1:0] WORDS    = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   x_q, x_d;
  logic [DATA_WIDTH-1:0]   c_q, c_d;
  logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0]   s_q, s_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0]   c_final_q, c_final_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   z_pipe_q [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]   z_pipe_d [PIPE_STAGES];

  logic                    stall;
  logic                    pipe_en;
  logic                    accept;
  logic                    final_xfer;
  logic                    mul_valid;
  logic [2*DATA_WIDTH-1:0] mul_p;
  logic [2*DATA_WIDTH-1:0] sum;

  assign stall      = out_valid_q & ~out_ready;
  assign pipe_en    = ~stall;
  assign in_ready   = busy_q & (in_cnt_q < WORDS) & ~stall;
  assign accept     = in_valid & in_ready;
  assign final_xfer = out_valid_q & out_ready & out_last_q;

  mul_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PIPE_STAGES (PIPE_STAGES)
  ) u_mul_pipe (
    .clk       (clk),
    .rst       (rst),
    .en        (pipe_en),
    .in_valid  (accept),
    .a         (x_q),
    .b         (y_in),
    .out_valid (mul_valid),
    .p         (mul_p)
  );

  // z travels beside the product so it meets it at the add stage
  always_comb begin
    z_pipe_d = z_pipe_q;
    if (pipe_en) begin
      z_pipe_d[0] = z_in;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        z_pipe_d[i] = z_pipe_q[i-1];
      end
    end
  end

  assign sum = mul_p
             + {{DATA_WIDTH{1'b0}}, z_pipe_q[PIPE_STAGES-1]}
             + {{DATA_WIDTH{1'b0}}, c_q};

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    s_d         = s_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    c_final_d   = c_final_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (!stall) begin
      if (accept) begin
        in_cnt_d = in_cnt_q + 1'b1;
      end
      if (mul_valid) begin
        s_d         = sum[DATA_WIDTH-1:0];
        c_d         = sum[2*DATA_WIDTH-1:DATA_WIDTH];
        out_valid_d = 1'b1;
        out_last_d  = (out_cnt_q == LAST_IDX);
        out_cnt_d   = out_cnt_q + 1'b1;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d       = x_in;
          c_d       = carry_in;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_cnt_q == WORDS) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (final_xfer) begin
          c_final_d = c_q;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      c_q         <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      c_final_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
        z_pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      c_q         <= c_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      c_final_q   <= c_final_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      z_pipe_q    <= z_pipe_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign s_out     = s_q;
  assign out_last  = out_last_q;
  assign c_final   = c_final_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mul_add_row.sv
// Bench for mul_add_row: directed and random rows checked against a plain-arithmetic row model.
module tb_mul_add_row;

  localparam int W = 8;
  localparam int N = 4;
  localparam int P = 2;

  typedef logic [W-1:0] row_t [N];

  logic         clk = 1'b0;
  logic         rst, start, in_valid, out_ready;
  logic [W-1:0] x_in, carry_in, y_in, z_in;
  logic         busy, in_ready, out_valid, out_last, done;
  logic [W-1:0] s_out, c_final;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mul_add_row #(
    .DATA_WIDTH  (W),
    .NUM_WORDS   (N),
    .PIPE_STAGES (P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_in      (x_in),
    .carry_in  (carry_in),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_out     (s_out),
    .out_last  (out_last),
    .c_final   (c_final),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one row; rst_after>0 aborts the row with a reset once that many outputs are taken.
  task automatic run_row(input logic [W-1:0] x, input logic [W-1:0] cin,
                         input row_t ys, input row_t zs, input int gap_pct,
                         input int stall_after, input int stall_len,
                         input int rst_after, input bit start_mid);
    int  exp_s [N];
    int  c, t;
    int  idx = 0, nout = 0, stalls = 0, acc_cyc = -1, first_out = -1;
    bit  got_done = 1'b0;
    c = cin;
    for (int j = 0; j < N; j++) begin
      t = int'(x) * int'(ys[j]) + int'(zs[j]) + c;
      exp_s[j] = t % 256;
      c = t / 256;
    end

    start = 1'b1; x_in = x; carry_in = cin;
    @(negedge clk);
    start = 1'b0; x_in = ~x; carry_in = ~cin;
    chk("busy_after_start", 32'(busy), 1);

    for (int k = 0; k < 200 && !got_done; k++) begin
      in_valid = (idx < N) && ($urandom_range(99) >= gap_pct);
      if (idx < N) begin
        y_in = in_valid ? ys[idx] : W'($urandom);
        z_in = in_valid ? zs[idx] : W'($urandom);
      end else begin
        y_in = W'($urandom);
        z_in = W'($urandom);
      end
      out_ready = !(nout >= stall_after && stalls < stall_len);
      start = start_mid && (k == 2);
      #1;
      if (!out_ready) stalls++;
      if (out_valid && !out_ready) chk("in_ready_during_stall", 32'(in_ready), 0);
      if (done) begin
        chk("outputs_before_done", nout, N);
        chk("c_final", 32'(c_final), c);
        chk("busy_at_done", 32'(busy), 0);
        got_done = 1'b1;
      end
      if (in_valid && in_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        idx++;
      end
      if (out_valid && first_out < 0) begin
        first_out = cyc;
        chk("first_out_latency", cyc - acc_cyc, P + 1);
      end
      if (out_valid && out_ready) begin
        if (nout < N) begin
          chk($sformatf("s_out[%0d]", nout), 32'(s_out), exp_s[nout]);
          chk($sformatf("out_last[%0d]", nout), 32'(out_last), 32'(nout == N - 1));
        end else begin
          chk("extra_output", nout, N - 1);
        end
        nout++;
      end
      @(negedge clk);
      start = 1'b0;
      if (rst_after > 0 && nout == rst_after) begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_done", 32'(done), 0);
        for (int q = 0; q < 6; q++) begin
          @(negedge clk);
          if (done || out_valid) chk("rst_no_activity", {30'd0, done, out_valid}, 0);
        end
        return;
      end
    end

    if (!got_done) begin
      chk("row_timeout", 0, 1);
    end else begin
      chk("done_pulse_width", 32'(done), 0);
      chk("c_final_hold", 32'(c_final), c);
      chk("busy_after_done", 32'(busy), 0);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    row_t r_y1, r_z0, r_ff, r_10, r_f0, ry, rz;
    r_y1 = '{8'd1, 8'd2, 8'd3, 8'd4};
    r_z0 = '{8'd0, 8'd0, 8'd0, 8'd0};
    r_ff = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    r_10 = '{8'h10, 8'h10, 8'h10, 8'h10};
    r_f0 = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; carry_in = '0; y_in = '0; z_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_s_out",     32'(s_out), 0);
    chk("reset_c_final",   32'(c_final), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_last",  32'(out_last), 0);
    chk("reset_busy",      32'(busy), 0);
    chk("reset_done",      32'(done), 0);
    chk("reset_in_ready",  32'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);

    // basic row, saturation, carry chain
    run_row(8'd2, 8'd0, r_y1, r_z0, 0, 0, 0, 0, 1'b0);
    run_row(8'hFF, 8'hFF, r_ff, r_ff, 0, 0, 0, 0, 1'b0);
    run_row(8'h10, 8'h00, r_10, r_f0, 0, 0, 0, 0, 1'b0);

    // backpressure with input gaps
    run_row(8'd2, 8'd0, r_y1, r_z0, 40, 2, 5, 0, 1'b0);

    // reset mid-row, then a clean repeat
    run_row(8'd2, 8'd0, r_y1, r_z0, 0, 0, 0, 2, 1'b0);
    run_row(8'd2, 8'd0, r_y1, r_z0, 0, 0, 0, 0, 1'b0);

    // in_valid while idle is ignored; start during RUN is ignored
    in_valid = 1'b1; y_in = 8'h55; z_in = 8'hAA;
    repeat (3) begin
      #1;
      chk("idle_in_ready", 32'(in_ready), 0);
      chk("idle_out_valid", 32'(out_valid), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    run_row(8'd2, 8'd0, r_y1, r_z0, 0, 0, 0, 0, 1'b1);

    // random rows
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < N; j++) begin
        ry[j] = W'($urandom);
        rz[j] = W'($urandom);
      end
      run_row(W'($urandom), W'($urandom), ry, rz, $urandom_range(50),
              $urandom_range(N - 1), $urandom_range(4), 0, 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
